// File: rtl/aes256_stream_master.sv
// ---------------------------------------------------------------------------
// aes256_stream_master
//
// Bus initiator for the AES-256 co-processor register socket. When a job
// starts, the block first resets the co-processor. It then programs the
// nonce and the key and sets run. After that it moves payload words from a
// valid/ready source into the co-processor input FIFO (register 13). Result
// words come back from register 14 and go to a valid/ready sink. At the end
// of the job it clears run and pulses done.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start                 begin a job (sampled only while idle)
//   num_blocks            number of 128-bit blocks, latched on start
//   key_in, nonce_in      AES key and initial counter, latched on start
//   in_data/in_valid/in_ready     payload word source
//   out_data/out_valid/out_ready  result word sink (single holding register)
//   busy                  high whenever a job is in progress
//   done                  one-cycle pulse at the end of a job
//   cop_addr/cop_wdata/cop_write_en  co-processor register bus (outgoing)
//   cop_rdata             co-processor read data, combinational from cop_addr
// ---------------------------------------------------------------------------
module aes256_stream_master #(
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [CNTW-1:0] num_blocks,
    input  logic [255:0]    key_in,
    input  logic [127:0]    nonce_in,
    input  logic [31:0]     in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic [3:0]      cop_addr,
    output logic [31:0]     cop_wdata,
    output logic            cop_write_en,
    input  logic [31:0]     cop_rdata
);

    typedef enum logic [3:0] {
        IDLE,
        CRST,
        CREL,
        NONCE,
        KEY,
        RUN,
        POLL,
        PEEK,
        POP,
        PUSH,
        STOP,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]      idx;
    logic [255:0]    key_q;
    logic [127:0]    nonce_q;
    logic [CNTW+1:0] total;
    logic [CNTW+1:0] pushed;
    logic [CNTW+1:0] popped;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Job context. The key, the nonce and the word total are captured on an
    // accepted start. idx walks through the nonce and key words. The two word
    // counters track how far the job has got in each direction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_q   <= '0;
            nonce_q <= '0;
            total   <= '0;
            pushed  <= '0;
            popped  <= '0;
            idx     <= '0;
        end else begin
            if (state == IDLE && start) begin
                key_q   <= key_in;
                nonce_q <= nonce_in;
                total   <= {num_blocks, 2'b00};
                pushed  <= '0;
                popped  <= '0;
            end
            if (state == PUSH) begin
                pushed <= pushed + 1'b1;
            end
            if (state == POP) begin
                popped <= popped + 1'b1;
            end
            if ((state == NONCE && idx == 3'd3) || (state == KEY && idx == 3'd7)) begin
                idx <= '0;
            end else if (state == NONCE || state == KEY) begin
                idx <= idx + 3'd1;
            end else begin
                idx <= '0;
            end
        end
    end

    // Single result holding register. PEEK loads it. A sink handshake empties
    // it, whatever the FSM is doing. POLL never enters PEEK while the
    // register is full, so a load and a drain never happen in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state == PEEK) begin
            out_data  <= cop_rdata;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Next-state logic. In POLL, popping comes before pushing. A full output
    // side must drain, otherwise the co-processor can stall with its input
    // FIFO full.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_blocks == '0) ? DONE : CRST;
                end
            end
            CRST:  next_state = CREL;
            CREL:  next_state = NONCE;
            NONCE: if (idx == 3'd3) next_state = KEY;
            KEY:   if (idx == 3'd7) next_state = RUN;
            RUN:   next_state = POLL;
            POLL: begin
                if (popped == total) begin
                    next_state = STOP;
                end else if (!cop_rdata[27] && !out_valid && popped < total) begin
                    next_state = PEEK;
                end else if (!cop_rdata[30] && in_valid && pushed < total) begin
                    next_state = PUSH;
                end
            end
            PEEK:    next_state = POP;
            POP:     next_state = POLL;
            PUSH:    next_state = POLL;
            STOP:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus and handshake outputs. Exactly one bus access happens per cycle.
    // States that only read, such as POLL and PEEK, just present an address.
    always_comb begin
        cop_addr     = '0;
        cop_wdata    = '0;
        cop_write_en = 1'b0;
        in_ready     = 1'b0;
        done         = 1'b0;
        case (state)
            CRST: begin
                cop_wdata    = 32'd2;
                cop_write_en = 1'b1;
            end
            CREL: begin
                cop_write_en = 1'b1;
            end
            NONCE: begin
                cop_addr     = 4'd1 + {1'b0, idx};
                cop_wdata    = nonce_q[{idx[1:0], 5'd0} +: 32];
                cop_write_en = 1'b1;
            end
            KEY: begin
                cop_addr     = 4'd5 + {1'b0, idx};
                cop_wdata    = key_q[{idx, 5'd0} +: 32];
                cop_write_en = 1'b1;
            end
            RUN: begin
                cop_wdata    = 32'd1;
                cop_write_en = 1'b1;
            end
            PEEK: begin
                cop_addr = 4'd14;
            end
            POP: begin
                cop_addr     = 4'd14;
                cop_write_en = 1'b1;
            end
            PUSH: begin
                cop_addr     = 4'd13;
                cop_wdata    = in_data;
                cop_write_en = 1'b1;
                in_ready     = 1'b1;
            end
            STOP: begin
                cop_write_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/aes256_stream_master.md
Name: aes256_stream_master

Overview:
- Bus initiator that drives the AES-256 co-processor register socket: addr, data_in, write_en out; data_out back in.
- On start, it runs the following sequence:
  - reset the co-processor;
  - program the nonce and key;
  - set run;
  - stream payload words into register 13 and pull result words from register 14;
  - clear run and pulse done.
- Sits between a valid/ready word source/sink (DMA or CPU glue) and the co-processor.

Parameters:
- CNTW, 16, width of num_blocks; word counters are CNTW+2 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- num_blocks  in  CNTW  128-bit blocks to process; latched on start
- key_in  in  256  AES key; latched on start
- nonce_in  in  128  initial counter; latched on start
- in_data  in  32  payload word
- in_valid  in  1  source has a word; held until in_ready
- in_ready  out  1  word consumed this cycle
- out_data  out  32  result word
- out_valid  out  1  out_data valid; held until out_ready
- out_ready  in  1  sink accepts
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- cop_addr  out  4  co-processor register address
- cop_wdata  out  32  co-processor write data
- cop_write_en  out  1  co-processor write strobe
- cop_rdata  in  32  co-processor read data, combinational from cop_addr

Behaviour:
- Reset: async, returns to IDLE. All outputs 0; counters and the out register are cleared. The co-processor is not touched until the next start.
- Register map driven:
  - 0 is status/control. Write bit0 = run, bit1 = reset. Read bit30 = input word FIFO full, bit27 = output word FIFO empty.
  - 1..4 are nonce words 0..3.
  - 5..12 are key words 0..7.
  - 13 writes a payload word.
  - 14 reads the output word FIFO head; writing 14 pops it.
- Idle bus: cop_addr=0, cop_write_en=0, cop_wdata=0. Exactly one bus access per cycle.
- Word order: nonce_in[32i+31:32i] goes to addr 1+i; key_in[32i+31:32i] goes to addr 5+i.
- FSM states and bus actions (all writes assert cop_write_en for exactly one cycle):
  - IDLE: on start, latch inputs. If num_blocks=0, go to DONE; else go to CRST.
  - CRST: write addr0 = 2. Then CREL.
  - CREL: write addr0 = 0. Then NONCE.
  - NONCE: 4 cycles, writing addr 1..4 in order. Then KEY.
  - KEY: 8 cycles, writing addr 5..12 in order. Then RUN.
  - RUN: write addr0 = 1. Then POLL.
  - First POLL occurs 16 cycles after the start cycle.
  - POLL: read addr0 with write_en=0, and decide from cop_rdata in the same cycle.
    - If popped == 4*num_blocks, go to STOP.
    - Else if bit27=0, !out_valid and popped < total, go to PEEK (pop has priority over push, to avoid deadlock).
    - Else if bit30=0, in_valid and pushed < total, go to PUSH.
    - Else stay in POLL.
  - PEEK: read addr14 with write_en=0. cop_rdata is registered into out_data and out_valid is set at the clock edge. Then POP.
  - POP: write addr14 (pop); popped++. Then POLL.
  - PUSH: write addr13 with cop_wdata=in_data; in_ready=1 this cycle only; pushed++. Then POLL.
  - STOP: write addr0 = 0 (run off). Then DONE.
  - DONE: done=1 for one cycle. Then IDLE.
- out register: out_valid clears on out_valid & out_ready and is independent of the FSM. It may still be high in DONE/IDLE. At most one result word is ever held.
- in_ready is combinational: high only in PUSH.
- start while busy is ignored.
- Counters never exceed total (4*num_blocks). No wrap inside a job.

Test Plan:
- Reset:
  - Assert reset mid-cycle → all outputs 0 immediately and state IDLE.
  - Release, then start → CRST write (addr0, 2) on the next cycle.
- Setup sequence:
  - Stimulus: key_in=256'h00..1F (bytes ascending), nonce_in=128'hF0..FF, num_blocks=1.
  - Required writes in order: (0,2), (0,0), (1,32'hFCFDFEFF), …, (4,32'hF0F1F2F3), (5,32'h1C1D1E1F), …, (12,32'h00010203), (0,1).
  - No gaps; first POLL at start+16.
- Single block with behavioural co-processor model:
  - Push words 32'h11111111..44444444.
  - 4 PEEK/POP pairs follow; out_data sequence matches the model XOR keystream.
  - Then STOP writes (0,0), done pulses once, busy falls.
- Sink backpressure:
  - num_blocks=2 with out_ready held low for 20 cycles.
  - Exactly one PEEK/POP occurs and out_valid stays high with stable data.
  - Pushes continue up to 8 words.
  - On release, all 8 words arrive in order.
- Source stall / full:
  - in_valid low or status bit30=1 → no addr13 writes and in_ready stays 0.
  - Resuming in_valid → push occurs within 2 cycles.
- Zero length and abort:
  - num_blocks=0 → done 1 cycle after start with no bus writes.
  - Reset during the STREAM phase (POLL/PEEK/POP/PUSH) → IDLE.
  - A new start then completes correctly.
